// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding, reset PC and the 64-bit instruction pair.
package instruction_fetch_pkg;
   localparam int DATA_W = 32;
   localparam logic [DATA_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

   typedef logic [2*DATA_W-1:0] fetch_pair_t;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/ifetch_perf_counter.sv
// Free-running fetch performance counters (instructions written, fifo_full stall cycles).
module ifetch_perf_counter
   import instruction_fetch_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              write_en1,
   input  logic              write_en2,
   input  logic              stall,
   output logic [DATA_W-1:0] perf_fetched,
   output logic [DATA_W-1:0] perf_stall
);
   logic [1:0] fetch_inc;

   assign fetch_inc = {1'b0, write_en1} + {1'b0, write_en2};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         perf_fetched <= perf_fetched + DATA_W'(fetch_inc);
         if (stall)
            perf_stall <= perf_stall + 1'b1;
      end
   end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding 8-byte icache request, redirect drop, dual-slot FIFO write.
// Optional counters built when IFETCH_PERF_CNT_EN is defined; otherwise perf_* read 0.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [DATA_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [DATA_W-1:0] redirect_pc,
   input  logic              fifo_full,
   output logic              icache_req_valid,
   output logic [DATA_W-1:0] icache_req_addr,
   input  logic              icache_req_ready,
   input  logic              icache_resp_valid,
   input  fetch_pair_t       icache_resp_data,
   output logic              write_en1,
   output logic              write_en2,
   output logic [DATA_W-1:0] write_data1,
   output logic [DATA_W-1:0] write_data2,
   output logic [DATA_W-1:0] write_address1,
   output logic [DATA_W-1:0] write_address2,
   output logic [DATA_W-1:0] perf_fetched,
   output logic [DATA_W-1:0] perf_stall
);
   fetch_state_t      state;
   logic [DATA_W-1:0] pc;
   logic [DATA_W-1:0] req_pc;
   logic              req_fire;

   // rst gating keeps the request low while the async reset is held
   assign icache_req_valid = !rst && (state == S_REQ) && !fifo_full && !redirect_valid;
   assign icache_req_addr  = {pc[DATA_W-1:3], 3'b000};
   assign req_fire         = icache_req_valid && icache_req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_REQ;
         pc             <= RESET_PC;
         req_pc         <= RESET_PC;
         write_en1      <= 1'b0;
         write_en2      <= 1'b0;
         write_data1    <= '0;
         write_data2    <= '0;
         write_address1 <= '0;
         write_address2 <= '0;
      end else begin
         write_en1      <= 1'b0;
         write_en2      <= 1'b0;
         write_data1    <= '0;
         write_data2    <= '0;
         write_address1 <= '0;
         write_address2 <= '0;
         case (state)
            S_REQ: begin
               if (redirect_valid) begin
                  pc <= redirect_pc;
               end else if (req_fire) begin
                  req_pc <= pc;
                  state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (redirect_valid) begin
                  pc    <= redirect_pc;
                  state <= icache_resp_valid ? S_REQ : S_DROP;
               end else if (icache_resp_valid) begin
                  state          <= S_REQ;
                  write_en1      <= 1'b1;
                  write_address1 <= req_pc;
                  if (!req_pc[2]) begin
                     write_data1    <= icache_resp_data[DATA_W-1:0];
                     write_en2      <= 1'b1;
                     write_data2    <= icache_resp_data[2*DATA_W-1:DATA_W];
                     write_address2 <= req_pc + 32'd4;
                     pc             <= req_pc + 32'd8;
                  end else begin
                     write_data1 <= icache_resp_data[2*DATA_W-1:DATA_W];
                     pc          <= req_pc + 32'd4;
                  end
               end
            end
            S_DROP: begin
               // the stale response is consumed even if yet another redirect arrives with it
               if (redirect_valid)
                  pc <= redirect_pc;
               if (icache_resp_valid)
                  state <= S_REQ;
            end
            default: state <= S_REQ;
         endcase
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   logic stall;

   assign stall = (state == S_REQ) && fifo_full && !redirect_valid;

   ifetch_perf_counter u_perf (
      .clk          (clk),
      .rst          (rst),
      .write_en1    (write_en1),
      .write_en2    (write_en2),
      .stall        (stall),
      .perf_fetched (perf_fetched),
      .perf_stall   (perf_stall)
   );
`else
   assign perf_fetched = '0;
   assign perf_stall   = '0;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed vector bench for instruction_fetch: per-cycle input/expected-output table plus reset sequences.
module tb_instruction_fetch;
   import instruction_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fifo_full;
   logic        icache_req_valid;
   logic [31:0] icache_req_addr;
   logic        icache_req_ready;
   logic        icache_resp_valid;
   logic [63:0] icache_resp_data;
   logic        write_en1, write_en2;
   logic [31:0] write_data1, write_data2, write_address1, write_address2;
   logic [31:0] perf_fetched, perf_stall;

   int checks = 0;
   int errors = 0;

   instruction_fetch dut (
      .clk               (clk),
      .rst               (rst),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .fifo_full         (fifo_full),
      .icache_req_valid  (icache_req_valid),
      .icache_req_addr   (icache_req_addr),
      .icache_req_ready  (icache_req_ready),
      .icache_resp_valid (icache_resp_valid),
      .icache_resp_data  (icache_resp_data),
      .write_en1         (write_en1),
      .write_en2         (write_en2),
      .write_data1       (write_data1),
      .write_data2       (write_data2),
      .write_address1    (write_address1),
      .write_address2    (write_address2),
      .perf_fetched      (perf_fetched),
      .perf_stall        (perf_stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        redir;
      logic [31:0] rpc;
      logic        full;
      logic        rdy;
      logic        resp;
      logic [63:0] rdata;
      logic        e_rv;
      logic [31:0] e_addr;
      logic        e_we1;
      logic        e_we2;
      logic [31:0] e_d1, e_a1, e_d2, e_a2;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic redir, input logic [31:0] rpc, input logic full,
                      input logic rdy, input logic resp, input logic [63:0] rdata,
                      input logic e_rv, input logic [31:0] e_addr,
                      input logic e_we1, input logic [31:0] e_d1, input logic [31:0] e_a1,
                      input logic e_we2, input logic [31:0] e_d2, input logic [31:0] e_a2);
      vec_t v;
      v.redir = redir; v.rpc = rpc; v.full = full; v.rdy = rdy; v.resp = resp; v.rdata = rdata;
      v.e_rv = e_rv; v.e_addr = e_addr; v.e_we1 = e_we1; v.e_we2 = e_we2;
      v.e_d1 = e_d1; v.e_a1 = e_a1; v.e_d2 = e_d2; v.e_a2 = e_a2;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic chk_writes(input string tag, input logic we1, input logic [31:0] d1,
                             input logic [31:0] a1, input logic we2, input logic [31:0] d2,
                             input logic [31:0] a2);
      chk({tag, " write_en1"}, {31'd0, write_en1}, {31'd0, we1});
      chk({tag, " write_en2"}, {31'd0, write_en2}, {31'd0, we2});
      chk({tag, " write_data1"}, write_data1, d1);
      chk({tag, " write_address1"}, write_address1, a1);
      chk({tag, " write_data2"}, write_data2, d2);
      chk({tag, " write_address2"}, write_address2, a2);
   endtask

   task automatic drive(input logic redir, input logic [31:0] rpc, input logic full,
                        input logic rdy, input logic resp, input logic [63:0] rdata);
      redirect_valid = redir; redirect_pc = rpc; fifo_full = full;
      icache_req_ready = rdy; icache_resp_valid = resp; icache_resp_data = rdata;
   endtask

   initial begin
      logic [31:0] exp_fetched, exp_stall;
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);

      //    redir rpc           full rdy resp rdata                  rv addr          we1 d1            a1            we2 d2            a2
      add(0, 0,             0, 1, 0, 64'h0,                  1, 32'hBFC00000, 0, 0,            0,            0, 0,            0);
      add(0, 0,             0, 0, 1, 64'h22222222_11111111,  0, 32'hBFC00000, 0, 0,            0,            0, 0,            0);
      add(0, 0,             0, 1, 0, 64'h0,                  1, 32'hBFC00008, 1, 32'h11111111, 32'hBFC00000, 1, 32'h22222222, 32'hBFC00004);
      add(1, 32'h80000014,  0, 0, 1, 64'hDEADBEEF_CAFEF00D,  0, 32'hBFC00008, 0, 0,            0,            0, 0,            0);
      add(0, 0,             0, 1, 0, 64'h0,                  1, 32'h80000010, 0, 0,            0,            0, 0,            0);
      add(0, 0,             0, 0, 1, 64'hBBBBBBBB_AAAAAAAA,  0, 32'h80000010, 0, 0,            0,            0, 0,            0);
      add(0, 0,             0, 1, 0, 64'h0,                  1, 32'h80000018, 1, 32'hBBBBBBBB, 32'h80000014, 0, 0,            0);
      add(0, 0,             0, 0, 1, 64'h44444444_33333333,  0, 32'h80000018, 0, 0,            0,            0, 0,            0);
      add(0, 0,             1, 1, 0, 64'h0,                  0, 32'h80000020, 1, 32'h33333333, 32'h80000018, 1, 32'h44444444, 32'h8000001C);
      for (int i = 0; i < 4; i++)
         add(0, 0,          1, 1, 0, 64'h0,                  0, 32'h80000020, 0, 0,            0,            0, 0,            0);
      add(0, 0,             0, 0, 0, 64'h0,                  1, 32'h80000020, 0, 0,            0,            0, 0,            0);
      add(0, 0,             0, 1, 0, 64'h0,                  1, 32'h80000020, 0, 0,            0,            0, 0,            0);
      add(1, 32'h90000000,  0, 0, 0, 64'h0,                  0, 32'h80000020, 0, 0,            0,            0, 0,            0);
      add(0, 0,             0, 1, 0, 64'h0,                  0, 32'h90000000, 0, 0,            0,            0, 0,            0);
      add(0, 0,             0, 1, 0, 64'h0,                  0, 32'h90000000, 0, 0,            0,            0, 0,            0);
      add(0, 0,             0, 0, 1, 64'h12345678_9ABCDEF0,  0, 32'h90000000, 0, 0,            0,            0, 0,            0);
      add(0, 0,             0, 1, 0, 64'h0,                  1, 32'h90000000, 0, 0,            0,            0, 0,            0);
      add(0, 0,             0, 0, 1, 64'h66666666_55555555,  0, 32'h90000000, 0, 0,            0,            0, 0,            0);
      add(1, 32'hFFFFFFF8,  0, 1, 0, 64'h0,                  0, 32'h90000008, 1, 32'h55555555, 32'h90000000, 1, 32'h66666666, 32'h90000004);
      add(0, 0,             0, 1, 0, 64'h0,                  1, 32'hFFFFFFF8, 0, 0,            0,            0, 0,            0);
      add(0, 0,             0, 0, 1, 64'h88888888_77777777,  0, 32'hFFFFFFF8, 0, 0,            0,            0, 0,            0);
      add(0, 0,             0, 0, 0, 64'h0,                  1, 32'h00000000, 1, 32'h77777777, 32'hFFFFFFF8, 1, 32'h88888888, 32'hFFFFFFFC);

      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset req_valid", {31'd0, icache_req_valid}, 32'd0);
      chk("reset req_addr", icache_req_addr, 32'hBFC00000);
      chk_writes("reset", 0, 0, 0, 0, 0, 0);
      chk("reset perf_fetched", perf_fetched, 32'd0);
      chk("reset perf_stall", perf_stall, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         drive(vq[i].redir, vq[i].rpc, vq[i].full, vq[i].rdy, vq[i].resp, vq[i].rdata);
         #1;
         chk({tag, " req_valid"}, {31'd0, icache_req_valid}, {31'd0, vq[i].e_rv});
         chk({tag, " req_addr"}, icache_req_addr, vq[i].e_addr);
         chk_writes(tag, vq[i].e_we1, vq[i].e_d1, vq[i].e_a1, vq[i].e_we2, vq[i].e_d2, vq[i].e_a2);
         @(negedge clk);
      end

`ifdef IFETCH_PERF_CNT_EN
      exp_fetched = 32'd9;
      exp_stall   = 32'd5;
`else
      exp_fetched = 32'd0;
      exp_stall   = 32'd0;
`endif
      chk("perf_fetched after table", perf_fetched, exp_fetched);
      chk("perf_stall after table", perf_stall, exp_stall);

      // Enter S_WAIT at pc 0, then assert rst asynchronously mid-cycle
      drive(0, 0, 0, 1, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      #1;
      chk("wait req_valid", {31'd0, icache_req_valid}, 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("midrst req_valid", {31'd0, icache_req_valid}, 32'd0);
      chk("midrst req_addr", icache_req_addr, 32'hBFC00000);
      chk_writes("midrst", 0, 0, 0, 0, 0, 0);
      chk("midrst perf_fetched", perf_fetched, 32'd0);
      chk("midrst perf_stall", perf_stall, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 0, 1, 0, 0);
      #1;
      chk("postrst req_valid", {31'd0, icache_req_valid}, 32'd1);
      chk("postrst req_addr", icache_req_addr, 32'hBFC00000);
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 64'hA5A5A5A5_5A5A5A5A);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      #1;
      chk_writes("postrst", 1, 32'h5A5A5A5A, 32'hBFC00000, 1, 32'hA5A5A5A5, 32'hBFC00004);
      chk("postrst next addr", icache_req_addr, 32'hBFC00008);
      @(negedge clk);
`ifdef IFETCH_PERF_CNT_EN
      exp_fetched = 32'd2;
`else
      exp_fetched = 32'd0;
`endif
      chk("postrst perf_fetched", perf_fetched, exp_fetched);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
